uart_tx_arbiter: RTL and testbench

- Shares one UART frame transmitter (frame_en / data_frame / tx_done handshake) among NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until its byte marked req_last has completed.
- Enforces an optional idle gap between frames and a watchdog on tx_done.
- Sits between the packet sources (BTLE status/debug streams) and the UART TX instance.

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART frame transmitter
// among NUM_REQ byte streams, with optional inter-frame gap and tx_done watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned FRAME_WD       = 8,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*FRAME_WD-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         frame_en,
    output logic [FRAME_WD-1:0]          data_frame,
    input  logic                         tx_done,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic                last_q, last_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [FRAME_WD-1:0] data_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic                timeout_c;
    logic                decide_c;
    logic [IDX_W-1:0]    win_idx;
    logic                win_vld;
    logic [IDX_W:0]      rr_sum;

    logic [FRAME_WD-1:0] req_byte [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_byte[i] = req_data[i*FRAME_WD +: FRAME_WD];
    end

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        if ({1'b0, i} >= (IDX_W+1)'(NUM_REQ - 1)) return '0;
        return i + IDX_W'(1);
    endfunction

    // First valid requester at or above the pointer, with wrap; scanned from the
    // far end so the closest offset is written last.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        rr_sum  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            if (req_valid[rr_sum[IDX_W-1:0]]) begin
                win_idx = rr_sum[IDX_W-1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        data_d    = data_frame;
        grant_d   = grant;
        timeout_c = 1'b0;
        decide_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gidx_d  = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    data_d  = req_byte[win_idx];
                    last_d  = req_last[win_idx];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (GAP_CYCLES != 0) begin
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        decide_c = 1'b1;
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the rest of the packet and let others compete.
                    timeout_c = 1'b1;
                    grant_d   = '0;
                    ptr_d     = inc_wrap(gidx_q);
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) decide_c = 1'b1;
                else                                  gap_d    = gap_q + GAP_W'(1);
            end
            HOLD: begin
                if (req_valid[gidx_q]) begin
                    data_d  = req_byte[gidx_q];
                    last_d  = req_last[gidx_q];
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Post-frame decision: release on last byte, else continue or hold the lock.
        if (decide_c) begin
            if (last_q) begin
                grant_d = '0;
                ptr_d   = inc_wrap(gidx_q);
                state_d = IDLE;
            end else if (req_valid[gidx_q]) begin
                data_d  = req_byte[gidx_q];
                last_d  = req_last[gidx_q];
                state_d = LAUNCH;
            end else begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs; strobes are decoded from the next state
    // so they line up exactly with the LAUNCH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            gidx_q      <= '0;
            last_q      <= 1'b0;
            wd_q        <= '0;
            gap_q       <= '0;
            data_frame  <= '0;
            grant       <= '0;
            frame_en    <= 1'b0;
            req_ready   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            data_frame  <= data_d;
            grant       <= grant_d;
            frame_en    <= (state_d == LAUNCH);
            req_ready   <= (state_d == LAUNCH) ? grant_d : '0;
            busy        <= (state_d != IDLE);
            timeout_err <= timeout_c;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 2 requesters, no gap, short watchdog
    logic [1:0]  a_valid, a_last, a_ready, a_grant;
    logic [15:0] a_data;
    logic [7:0]  a_df;
    logic        a_fe, a_txd, a_busy, a_to;

    // Instance B: 2 requesters, 5-cycle gap
    logic [1:0]  b_valid, b_last, b_ready, b_grant;
    logic [15:0] b_data;
    logic [7:0]  b_df;
    logic        b_fe, b_txd, b_busy, b_to;

    uart_tx_arbiter #(.NUM_REQ(2), .FRAME_WD(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
        .req_ready(a_ready), .frame_en(a_fe), .data_frame(a_df), .tx_done(a_txd),
        .grant(a_grant), .busy(a_busy), .timeout_err(a_to));

    uart_tx_arbiter #(.NUM_REQ(2), .FRAME_WD(8), .GAP_CYCLES(5), .TIMEOUT_CYCLES(100)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .frame_en(b_fe), .data_frame(b_df), .tx_done(b_txd),
        .grant(b_grant), .busy(b_busy), .timeout_err(b_to));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model for instance A: completes each frame 1..8 cycles after launch
    bit         tx_auto;
    int         tx_cnt;
    logic [7:0] tx_lat;
    initial begin
        a_txd  = 1'b0;
        tx_cnt = 0;
        tx_lat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_txd  = 1'b0;
                tx_cnt = 0;
            end else begin
                a_txd = 1'b0;
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        a_txd = 1'b1;
                        chk("tx_hold", 32'(a_df), 32'(tx_lat));
                    end
                end
                if (a_fe) begin
                    tx_lat = a_df;
                    tx_cnt = tx_auto ? int'($urandom_range(8, 1)) : 0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        a_valid[i]       = v;
        a_data[i*8 +: 8] = d;
        a_last[i]        = l;
    endtask

    task automatic wait_launch(input string tag, input logic [7:0] exp_d, input logic [1:0] exp_g,
                               output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!a_fe && lat < 300);
        chk({tag, "_fe"},    32'(a_fe),    32'd1);
        chk({tag, "_data"},  32'(a_df),    32'(exp_d));
        chk({tag, "_grant"}, 32'(a_grant), 32'(exp_g));
        chk({tag, "_ready"}, 32'(a_ready), 32'(exp_g));
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (a_busy && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(a_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_fe"},    32'(a_fe),    32'd0);
        chk({tag, "_df"},    32'(a_df),    32'd0);
        chk({tag, "_grant"}, 32'(a_grant), 32'd0);
        chk({tag, "_busy"},  32'(a_busy),  32'd0);
        chk({tag, "_to"},    32'(a_to),    32'd0);
    endtask

    // Randomized-traffic requester and model state
    int         rem [2];
    int         gapc [2];
    logic [7:0] pd [2];
    logic       pl [2];
    bit         launched [2];
    bit         xfer_prev [2];
    bit         stop_new;

    task automatic present(input int i);
        if (rem[i] == 0) begin
            if (stop_new) return;
            rem[i] = int'($urandom_range(4, 1));
        end
        pd[i]       = 8'($urandom);
        pl[i]       = (rem[i] == 1);
        rem[i]--;
        launched[i] = 1'b0;
        set_req(i, 1'b1, pd[i], pl[i]);
    endtask

    task automatic run_random(input int cycles);
        int         m_ptr, m_owner, exp_own, n_launch;
        bit         m_in_pkt, last_out;
        logic [1:0] arb_v;
        m_ptr = 0; m_owner = 0; m_in_pkt = 1'b0; last_out = 1'b0; n_launch = 0;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; gapc[i] = int'($urandom_range(3, 0)); xfer_prev[i] = 1'b0;
            launched[i] = 1'b0; pd[i] = '0; pl[i] = 1'b0;
        end
        stop_new = 1'b0;
        for (int cyc = 0; cyc < cycles + 400; cyc++) begin
            if (cyc == cycles) stop_new = 1'b1;
            arb_v = a_valid;
            if (a_txd && last_out) begin
                chk("rnd_release", 32'(a_grant), 32'd0);
                last_out = 1'b0;
            end
            if (a_fe) begin
                exp_own = -1;
                if (m_in_pkt) exp_own = m_owner;
                else
                    for (int k = 0; k < 2; k++)
                        if (exp_own < 0 && arb_v[(m_ptr + k) % 2]) exp_own = (m_ptr + k) % 2;
                if (exp_own < 0) begin
                    chk("rnd_spurious_fe", 32'(a_fe), 32'd0);
                end else begin
                    chk("rnd_grant", 32'(a_grant), 32'(1 << exp_own));
                    chk("rnd_ready", 32'(a_ready), 32'(1 << exp_own));
                    chk("rnd_data",  32'(a_df),    32'(pd[exp_own]));
                    chk("rnd_fresh", 32'(launched[exp_own]), 32'd0);
                    launched[exp_own] = 1'b1;
                    n_launch++;
                    m_owner  = exp_own;
                    m_in_pkt = !pl[exp_own];
                    if (pl[exp_own]) begin
                        m_ptr    = (exp_own + 1) % 2;
                        last_out = 1'b1;
                    end
                end
            end else begin
                chk("rnd_ready_idle", 32'(a_ready), 32'd0);
            end
            for (int i = 0; i < 2; i++) begin
                if (xfer_prev[i]) begin
                    set_req(i, 1'b0, 8'h00, 1'b0);
                    if (pl[i]) gapc[i] = int'($urandom_range(6, 0));
                    else       gapc[i] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(12, 1)) : 0;
                end
                if (!a_valid[i]) begin
                    if (gapc[i] > 0) gapc[i]--;
                    else             present(i);
                end
                xfer_prev[i] = a_valid[i] && a_ready[i];
            end
            tick();
        end
        chk("rnd_activity", 32'(n_launch >= 100), 32'd1);
        chk("rnd_drained", 32'(a_busy), 32'd0);
    endtask

    initial begin
        int lat, n, idle;
        bit fe_seen;
        rst_n   = 1'b0;
        a_valid = '0; a_data = '0; a_last = '0;
        b_valid = '0; b_data = '0; b_last = '0; b_txd = 1'b0;
        tx_auto = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single byte
        set_req(0, 1'b1, 8'hA5, 1'b1);
        wait_launch("single", 8'hA5, 2'b01, lat);
        chk("single_lat", 32'(lat), 32'd1);
        set_req(0, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (!a_txd && n < 50) begin
            tick();
            n++;
        end
        chk("single_done",   32'(a_txd),   32'd1);
        chk("single_grant0", 32'(a_grant), 32'd0);
        chk("single_busy0",  32'(a_busy),  32'd0);

        // Round-robin between two always-ready single-byte sources
        do_reset();
        set_req(0, 1'b1, 8'h11, 1'b1);
        set_req(1, 1'b1, 8'h22, 1'b1);
        for (int k = 0; k < 4; k++)
            wait_launch($sformatf("rr%0d", k), (k % 2 == 1) ? 8'h22 : 8'h11,
                        (k % 2 == 1) ? 2'b10 : 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_idle("rr_idle");

        // Packet lock with a stalled owner
        do_reset();
        set_req(0, 1'b1, 8'h01, 1'b0);
        set_req(1, 1'b1, 8'h44, 1'b1);
        wait_launch("lock_b1", 8'h01, 2'b01, lat);
        set_req(0, 1'b1, 8'h02, 1'b0);
        wait_launch("lock_b2", 8'h02, 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        fe_seen = 1'b0;
        repeat (20) begin
            tick();
            fe_seen |= a_fe;
            chk("lock_hold_grant", 32'(a_grant), 32'b01);
        end
        chk("lock_no_fe", 32'(fe_seen), 32'd0);
        chk("lock_busy",  32'(a_busy),  32'd1);
        set_req(0, 1'b1, 8'h03, 1'b1);
        wait_launch("lock_b3", 8'h03, 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_launch("lock_r1", 8'h44, 2'b10, lat);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_idle("lock_idle");

        // Watchdog
        do_reset();
        tx_auto = 1'b0;
        set_req(0, 1'b1, 8'h31, 1'b1);
        set_req(1, 1'b1, 8'h22, 1'b1);
        wait_launch("to_launch", 8'h31, 2'b01, lat);
        set_req(0, 1'b1, 8'h33, 1'b1);
        n = 0;
        fe_seen = 1'b0;
        while (!a_to && n < 200) begin
            tick();
            n++;
            fe_seen |= a_fe;
        end
        chk("to_cycles", 32'(n),       32'd100);
        chk("to_pulse",  32'(a_to),    32'd1);
        chk("to_grant0", 32'(a_grant), 32'd0);
        chk("to_busy0",  32'(a_busy),  32'd0);
        chk("to_no_fe",  32'(fe_seen), 32'd0);
        tx_auto = 1'b1;
        wait_launch("to_next", 8'h22, 2'b10, lat);
        chk("to_next_lat", 32'(lat),  32'd1);
        chk("to_pulse_end", 32'(a_to), 32'd0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_launch("to_r0", 8'h33, 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_idle("to_idle");

        // Reset in the middle of a frame
        do_reset();
        set_req(0, 1'b1, 8'h61, 1'b1);
        wait_launch("rst_pre", 8'h61, 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_idle("rst_pre_idle");
        tx_auto = 1'b0;
        set_req(0, 1'b1, 8'h62, 1'b1);
        set_req(1, 1'b1, 8'h71, 1'b1);
        wait_launch("rst_r1", 8'h71, 2'b10, lat);
        tick();
        tick();
        chk("rst_busy_pre", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_async");
        @(negedge clk);
        rst_n   = 1'b1;
        tx_auto = 1'b1;
        wait_launch("rst_relaunch", 8'h62, 2'b01, lat);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_launch("rst_r1b", 8'h71, 2'b10, lat);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_idle("rst_idle");

        // Inter-frame gap on instance B
        b_valid = 2'b01; b_data[7:0] = 8'hB1; b_last = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_fe && n < 20);
        chk("gap_fe1",   32'(b_fe), 32'd1);
        chk("gap_data1", 32'(b_df), 32'hB1);
        tick();
        b_data[7:0] = 8'hB2; b_last = 2'b01;
        tick();
        tick();
        b_txd = 1'b1;
        tick();
        b_txd = 1'b0;
        idle = 0;
        while (!b_fe && idle < 20) begin
            idle++;
            tick();
        end
        chk("gap_idle",   32'(idle),    32'd5);
        chk("gap_data2",  32'(b_df),    32'hB2);
        chk("gap_grant2", 32'(b_grant), 32'b01);
        tick();
        b_valid = 2'b00;
        tick();
        b_txd = 1'b1;
        tick();
        b_txd = 1'b0;
        repeat (8) tick();
        chk("gap_end_busy",  32'(b_busy),  32'd0);
        chk("gap_end_grant", 32'(b_grant), 32'd0);

        // Randomized traffic against the packet-level model
        do_reset();
        tx_auto = 1'b1;
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
